// File: rtl/full_adder_pkg.sv
// Shared definitions for the registered ripple-carry full adder.
//   FA_DEFAULT_WIDTH : default operand width (single-bit classic full adder)
//   fa_result_t      : {cout, sum} result record at the default width
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;

  typedef struct packed {
    logic                        cout;
    logic [FA_DEFAULT_WIDTH-1:0] sum;
  } fa_result_t;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full-adder cell, the link of the ripple chain.
//   a, b, cin : operand bits and incoming carry
//   s         : sum bit
//   co        : carry out (majority of the three inputs)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit full adder: {cout,sum} = a + b + cin, one-cycle latency.
// Ripple chain of full_adder_cell instances; results captured when in_valid=1
// and held otherwise. Synchronous active-low reset has priority over in_valid.
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid, a, b, cin : operands, captured when in_valid=1
//   sum, cout         : registered result
//   out_valid         : high for one cycle after each captured operand set
//   ovf               : registered signed overflow, present only when the
//                       FULL_ADDER_OVF_EN macro is defined
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (w_carry[i]),
      .s   (w_sum[i]),
      .co  (w_carry[i+1])
    );
  end

  // Holding on in_valid=0 keeps X/Z on idle inputs away from the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_out_valid;

`ifdef FULL_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1;
  logic       v8, c8;
  logic [7:0] a8, b8, s8;
  logic       co8, ov8;
`ifdef FULL_ADDER_OVF_EN
  logic       of1, of8;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [8:0] res;
    logic       ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t h1, h8;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .cout(co1), .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(of1)
`endif
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .sum(s8), .cout(co8), .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(of8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive both DUTs for one cycle, push expectations, then check after the edge.
  task automatic step(input logic rn,
                      input logic ev1, input logic ea1, input logic eb1, input logic ec1,
                      input logic ev8, input logic [7:0] ea8, input logic [7:0] eb8,
                      input logic ec8);
    exp_t e;
    logic [8:0] r;
    rst_n = rn;
    v1 = ev1; a1 = ea1; b1 = eb1; c1 = ec1;
    v8 = ev8; a8 = ea8; b8 = eb8; c8 = ec8;
    if (!rn) begin
      q1.delete(); q8.delete();
      h1 = '{res: 9'd0, ovf: 1'b0};
      h8 = '{res: 9'd0, ovf: 1'b0};
    end else begin
      if (ev1) begin
        r = {8'd0, ea1} + {8'd0, eb1} + {8'd0, ec1};
        e.res = r;
        e.ovf = (ea1 == eb1) && (r[0] != ea1);
        q1.push_back(e);
      end
      if (ev8) begin
        r = {1'b0, ea8} + {1'b0, eb8} + {8'd0, ec8};
        e.res = r;
        e.ovf = (ea8[7] == eb8[7]) && (r[7] != ea8[7]);
        q8.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    // width-1 DUT
    if (rn && q1.size() > 0) begin
      h1 = q1.pop_front();
      chk("w1_out_valid", 32'(ov1), 32'd1);
    end else begin
      chk("w1_out_valid_low", 32'(ov1), 32'd0);
    end
    chk("w1_sum",  32'(s1),  32'(h1.res[0]));
    chk("w1_cout", 32'(co1), 32'(h1.res[1]));
    // width-8 DUT
    if (rn && q8.size() > 0) begin
      h8 = q8.pop_front();
      chk("w8_out_valid", 32'(ov8), 32'd1);
    end else begin
      chk("w8_out_valid_low", 32'(ov8), 32'd0);
    end
    chk("w8_sum",  32'(s8),  32'(h8.res[7:0]));
    chk("w8_cout", 32'(co8), 32'(h8.res[8]));
`ifdef FULL_ADDER_OVF_EN
    chk("w1_ovf", 32'(of1), 32'(h1.ovf));
    chk("w8_ovf", 32'(of8), 32'(h8.ovf));
`endif
  endtask

  initial begin
    // reset, with in_valid high to confirm reset wins
    step(0, 1, 1, 1, 1, 1, 8'hFF, 8'hFF, 1);
    step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);

    // directed width-1 vectors, back-to-back
    step(1, 1, 0, 1, 0, 0, 'x, 'x, 'x);
    step(1, 1, 1, 1, 0, 0, 'x, 'x, 'x);
    step(1, 1, 1, 1, 1, 0, 'x, 'x, 'x);
    step(1, 1, 0, 0, 0, 0, 'x, 'x, 'x);

    // exhaustive width-1
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step(1, 1, v[2], v[1], v[0], 0, 'x, 'x, 'x);
    end

    // idle cycle with X inputs: outputs hold, out_valid low
    step(1, 1, 1, 1, 0, 0, 'x, 'x, 'x);
    step(1, 0, 'x, 'x, 'x, 0, 'x, 'x, 'x);
    step(1, 0, 'x, 'x, 'x, 0, 'x, 'x, 'x);

    // width-8 boundaries
    step(1, 0, 'x, 'x, 'x, 1, 8'hFF, 8'h01, 0);
    step(1, 0, 'x, 'x, 'x, 1, 8'h12, 8'h34, 1);
    step(1, 0, 'x, 'x, 'x, 1, 8'h7F, 8'h01, 0);
    step(1, 0, 'x, 'x, 'x, 1, 8'h80, 8'h80, 0);
    step(1, 0, 'x, 'x, 'x, 1, 8'hFF, 8'hFF, 1);
    step(1, 0, 'x, 'x, 'x, 0, 'x, 'x, 'x);

    // both DUTs streaming together, then reset mid-stream
    step(1, 1, 1, 0, 1, 1, 8'h55, 8'hAA, 1);
    step(0, 1, 1, 1, 1, 1, 8'h7F, 8'h7F, 1);
    step(1, 1, 1, 1, 0, 1, 8'h01, 8'h02, 0);

    // random width-8 traffic with sporadic idles
    for (int i = 0; i < 40; i++) begin
      logic vv;
      vv = ($urandom_range(0, 3) != 0);
      step(1, vv, 1'($urandom), 1'($urandom), 1'($urandom),
           vv, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
